// File: rtl/bp_common_rv64_pkg.sv
// RV64 trap encoding shared types: mcause exception codes, trap priority order and tval source selection.
// Pure declarations; no timing or flow control of its own.
package bp_common_rv64_pkg;

    localparam int rv64_eaddr_width_gp = 64;
    localparam int rv64_exc_width_gp   = 16;
    localparam int rv64_exc_prio_num_gp = 14;

    typedef enum logic [3:0] {
        e_instr_misaligned    = 4'd0,
        e_instr_access_fault  = 4'd1,
        e_illegal_instr       = 4'd2,
        e_breakpoint          = 4'd3,
        e_load_misaligned     = 4'd4,
        e_load_access_fault   = 4'd5,
        e_store_misaligned    = 4'd6,
        e_store_access_fault  = 4'd7,
        e_ecall_u             = 4'd8,
        e_ecall_s             = 4'd9,
        e_ecall_m             = 4'd11,
        e_instr_page_fault    = 4'd12,
        e_load_page_fault     = 4'd13,
        e_store_page_fault    = 4'd15
    } rv64_exception_code_e;

    // Index 0 is the lowest priority; codes 10 and 14 are reserved and deliberately absent.
    localparam rv64_exception_code_e [rv64_exc_prio_num_gp-1:0] rv64_exc_prio_gp = {
        e_instr_page_fault,
        e_instr_access_fault,
        e_illegal_instr,
        e_instr_misaligned,
        e_ecall_m,
        e_ecall_s,
        e_ecall_u,
        e_breakpoint,
        e_store_misaligned,
        e_load_misaligned,
        e_store_page_fault,
        e_load_page_fault,
        e_store_access_fault,
        e_load_access_fault
    };

    typedef enum logic [1:0] {
        e_tval_zero,
        e_tval_pc,
        e_tval_vaddr,
        e_tval_instr
    } rv64_tval_src_e;

    typedef enum logic [1:0] {
        e_trap_idle,
        e_trap_pending,
        e_trap_drain
    } trap_state_e;

    function automatic rv64_tval_src_e rv64_tval_src(input logic [3:0] code);
        rv64_tval_src_e src;
        case (code)
            e_instr_page_fault,
            e_instr_access_fault,
            e_breakpoint:         src = e_tval_pc;
            e_illegal_instr:      src = e_tval_instr;
            e_ecall_u,
            e_ecall_s,
            e_ecall_m:            src = e_tval_zero;
            default:              src = e_tval_vaddr;
        endcase
        return src;
    endfunction

endpackage

// File: rtl/bp_be_trap_prio_encode.sv
// Collapses a multi-hot exception vector into the single highest-priority mcause code.
// Purely combinational, zero latency; no flow control.
module bp_be_trap_prio_encode
    import bp_common_rv64_pkg::*;
(
    input  logic [rv64_exc_width_gp-1:0] exc_i,
    output logic                         found_o,
    output logic [3:0]                   code_o
);

    // Walk from lowest to highest priority so the last hit is the winner.
    always_comb begin
        found_o = 1'b0;
        code_o  = 4'd0;
        for (int i = 0; i < rv64_exc_prio_num_gp; i++) begin
            if (exc_i[rv64_exc_prio_gp[i]]) begin
                found_o = 1'b1;
                code_o  = rv64_exc_prio_gp[i];
            end
        end
    end

endmodule

// File: rtl/bp_be_trap_encoder.sv
// Turns a committed exception vector into one held architectural trap (cause, tval, epc) for the CSR unit.
// Accept at edge N -> trap valid from N+1; stalls intake while a trap is held and for drain_cycles_p after it is consumed.
module bp_be_trap_encoder
    import bp_common_rv64_pkg::*;
#(
    parameter int vaddr_width_p  = 39,
    parameter int drain_cycles_p = 2
)
(
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           exc_v_i,
    output logic                           exc_ready_o,
    input  logic [rv64_exc_width_gp-1:0]   exc_i,
    input  logic [vaddr_width_p-1:0]       pc_i,
    input  logic [31:0]                    instr_i,
    input  logic [vaddr_width_p-1:0]       vaddr_i,
    input  logic                           flush_i,
    output logic                           trap_v_o,
    input  logic                           trap_yumi_i,
    output logic [3:0]                     cause_o,
    output logic [rv64_eaddr_width_gp-1:0] tval_o,
    output logic [rv64_eaddr_width_gp-1:0] epc_o
);

    localparam int cnt_width_lp = (drain_cycles_p > 0) ? $clog2(drain_cycles_p + 1) : 1;
    localparam logic [cnt_width_lp-1:0] cnt_last_lp =
        cnt_width_lp'((drain_cycles_p > 0) ? (drain_cycles_p - 1) : 0);
    localparam int ext_width_lp = rv64_eaddr_width_gp - vaddr_width_p;

    trap_state_e                     r_state;
    trap_state_e                     w_state_n;
    logic [cnt_width_lp-1:0]         r_cnt;
    logic [cnt_width_lp-1:0]         w_cnt_n;
    logic                            r_trap_v;
    logic                            w_trap_v_n;
    logic [3:0]                      r_cause;
    logic [3:0]                      w_cause_n;
    logic [rv64_eaddr_width_gp-1:0]  r_tval;
    logic [rv64_eaddr_width_gp-1:0]  w_tval_n;
    logic [rv64_eaddr_width_gp-1:0]  r_epc;
    logic [rv64_eaddr_width_gp-1:0]  w_epc_n;

    logic                            w_accept;
    logic                            w_found;
    logic [3:0]                      w_code;
    logic [rv64_eaddr_width_gp-1:0]  w_pc_sext;
    logic [rv64_eaddr_width_gp-1:0]  w_vaddr_sext;
    logic [rv64_eaddr_width_gp-1:0]  w_tval;

    bp_be_trap_prio_encode u_prio (
        .exc_i   (exc_i),
        .found_o (w_found),
        .code_o  (w_code)
    );

    assign exc_ready_o  = (r_state == e_trap_idle) & ~reset_i;
    assign w_accept     = exc_v_i & exc_ready_o;
    assign w_pc_sext    = {{ext_width_lp{pc_i[vaddr_width_p-1]}}, pc_i};
    assign w_vaddr_sext = {{ext_width_lp{vaddr_i[vaddr_width_p-1]}}, vaddr_i};

    always_comb begin
        w_tval = '0;
        unique case (rv64_tval_src(w_code))
            e_tval_pc:    w_tval = w_pc_sext;
            e_tval_vaddr: w_tval = w_vaddr_sext;
            e_tval_instr: w_tval = {{(rv64_eaddr_width_gp-32){1'b0}}, instr_i};
            e_tval_zero:  w_tval = '0;
        endcase
    end

    always_comb begin
        w_state_n  = r_state;
        w_cnt_n    = r_cnt;
        w_trap_v_n = r_trap_v;
        w_cause_n  = r_cause;
        w_tval_n   = r_tval;
        w_epc_n    = r_epc;
        // Flush squashes everything, including a same-cycle accept or consume.
        if (flush_i) begin
            w_state_n  = e_trap_idle;
            w_cnt_n    = '0;
            w_trap_v_n = 1'b0;
        end else begin
            unique case (r_state)
                e_trap_idle: begin
                    if (w_accept && w_found) begin
                        w_state_n  = e_trap_pending;
                        w_trap_v_n = 1'b1;
                        w_cause_n  = w_code;
                        w_tval_n   = w_tval;
                        w_epc_n    = w_pc_sext;
                    end
                end
                e_trap_pending: begin
                    if (trap_yumi_i) begin
                        w_trap_v_n = 1'b0;
                        w_cnt_n    = '0;
                        w_state_n  = (drain_cycles_p == 0) ? e_trap_idle : e_trap_drain;
                    end
                end
                e_trap_drain: begin
                    if (r_cnt == cnt_last_lp) begin
                        w_state_n = e_trap_idle;
                    end else begin
                        w_cnt_n = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_n = e_trap_idle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state  <= e_trap_idle;
            r_cnt    <= '0;
            r_trap_v <= 1'b0;
            r_cause  <= 4'd0;
            r_tval   <= '0;
            r_epc    <= '0;
        end else begin
            r_state  <= w_state_n;
            r_cnt    <= w_cnt_n;
            r_trap_v <= w_trap_v_n;
            r_cause  <= w_cause_n;
            r_tval   <= w_tval_n;
            r_epc    <= w_epc_n;
        end
    end

    assign trap_v_o = r_trap_v;
    assign cause_o  = r_cause;
    assign tval_o   = r_tval;
    assign epc_o    = r_epc;

    // Consuming a trap that is not being offered is a caller bug.
    a_yumi_needs_trap: assert property (@(posedge clk_i) disable iff (reset_i) trap_yumi_i |-> r_trap_v);

endmodule

// File: tb/tb_bp_be_trap_encoder.sv
// Directed and randomized check of bp_be_trap_encoder against a cycle-level behavioural model.
module tb_bp_be_trap_encoder;

    localparam int VW    = 39;
    localparam int DRAIN = 2;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic          exc_v_i;
    logic          exc_ready_o;
    logic [15:0]   exc_i;
    logic [VW-1:0] pc_i;
    logic [31:0]   instr_i;
    logic [VW-1:0] vaddr_i;
    logic          flush_i;
    logic          trap_v_o;
    logic          trap_yumi_i;
    logic [3:0]    cause_o;
    logic [63:0]   tval_o;
    logic [63:0]   epc_o;

    int n_cmp = 0;
    int n_bad = 0;

    bit          m_pending;
    int          m_drain_left;
    logic [3:0]  m_cause;
    logic [63:0] m_tval;
    logic [63:0] m_epc;

    bp_be_trap_encoder #(.vaddr_width_p(VW), .drain_cycles_p(DRAIN)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .exc_v_i     (exc_v_i),
        .exc_ready_o (exc_ready_o),
        .exc_i       (exc_i),
        .pc_i        (pc_i),
        .instr_i     (instr_i),
        .vaddr_i     (vaddr_i),
        .flush_i     (flush_i),
        .trap_v_o    (trap_v_o),
        .trap_yumi_i (trap_yumi_i),
        .cause_o     (cause_o),
        .tval_o      (tval_o),
        .epc_o       (epc_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int pick_cause(input logic [15:0] e);
        int order [14] = '{12, 1, 2, 0, 11, 9, 8, 3, 6, 4, 15, 13, 7, 5};
        foreach (order[i]) if (e[order[i]]) return order[i];
        return -1;
    endfunction

    function automatic logic [63:0] exp_tval(input int c, input logic [VW-1:0] pc,
                                             input logic [VW-1:0] va, input logic [31:0] ins);
        logic signed [63:0] spc;
        logic signed [63:0] sva;
        spc = $signed(pc);
        sva = $signed(va);
        case (c)
            12, 1, 3: return spc;
            2:        return {32'd0, ins};
            8, 9, 11: return 64'd0;
            default:  return sva;
        endcase
    endfunction

    task automatic model_step();
        int c;
        if (flush_i) begin
            m_pending    = 1'b0;
            m_drain_left = 0;
        end else if (m_pending) begin
            if (trap_yumi_i) begin
                m_pending    = 1'b0;
                m_drain_left = DRAIN;
            end
        end else if (m_drain_left > 0) begin
            m_drain_left--;
        end else if (exc_v_i) begin
            c = pick_cause(exc_i);
            if (c >= 0) begin
                logic signed [63:0] spc;
                spc       = $signed(pc_i);
                m_pending = 1'b1;
                m_cause   = 4'(c);
                m_tval    = exp_tval(c, pc_i, vaddr_i, instr_i);
                m_epc     = spc;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".trap_v"}, 64'(trap_v_o), 64'(m_pending));
        chk({tag, ".ready"}, 64'(exc_ready_o), 64'(!m_pending && m_drain_left == 0));
        if (m_pending) begin
            chk({tag, ".cause"}, 64'(cause_o), 64'(m_cause));
            chk({tag, ".tval"}, tval_o, m_tval);
            chk({tag, ".epc"}, epc_o, m_epc);
        end
    endtask

    initial begin
        reset_i = 1'b1; exc_v_i = 1'b0; exc_i = '0; pc_i = '0; instr_i = '0;
        vaddr_i = '0; flush_i = 1'b0; trap_yumi_i = 1'b0;
        m_pending = 1'b0; m_drain_left = 0; m_cause = '0; m_tval = '0; m_epc = '0;

        #1;
        chk("rst.trap_v", 64'(trap_v_o), 64'd0);
        chk("rst.ready", 64'(exc_ready_o), 64'd0);
        chk("rst.cause", 64'(cause_o), 64'd0);
        chk("rst.tval", tval_o, 64'd0);
        chk("rst.epc", epc_o, 64'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        tick();
        chk("post_rst.ready", 64'(exc_ready_o), 64'd1);

        // Single illegal-instruction cause
        exc_v_i = 1'b1; exc_i = 16'h0004; instr_i = 32'hFFFF_FFFF;
        pc_i = VW'(32'h0000_1234); vaddr_i = VW'(32'h0000_5678);
        tick();
        exc_v_i = 1'b0;
        chk("single.trap_v", 64'(trap_v_o), 64'd1);
        chk("single.cause", 64'(cause_o), 64'd2);
        chk("single.tval", tval_o, 64'h0000_0000_FFFF_FFFF);
        cmp_model("single");

        // Consume and drain; intake during drain must be ignored
        trap_yumi_i = 1'b1;
        tick();
        trap_yumi_i = 1'b0;
        chk("drain1.ready", 64'(exc_ready_o), 64'd0);
        chk("drain1.trap_v", 64'(trap_v_o), 64'd0);
        exc_v_i = 1'b1; exc_i = 16'h0004;
        tick();
        chk("drain2.ready", 64'(exc_ready_o), 64'd0);
        tick();
        exc_v_i = 1'b0;
        chk("drain3.ready", 64'(exc_ready_o), 64'd1);
        chk("drain3.trap_v", 64'(trap_v_o), 64'd0);

        // Priority among many causes
        exc_v_i = 1'b1; exc_i = 16'hA0D1;
        pc_i = 39'h40_0000_1000; vaddr_i = 39'h7F_FFFF_FFF8;
        tick();
        exc_v_i = 1'b0;
        chk("prio.cause", 64'(cause_o), 64'd0);
        chk("prio.tval", tval_o, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("prio.epc", epc_o, 64'hFFFF_FFC0_0000_1000);
        cmp_model("prio");

        // Flush beats a same-cycle consume: no drain window
        flush_i = 1'b1; trap_yumi_i = 1'b1;
        tick();
        flush_i = 1'b0; trap_yumi_i = 1'b0;
        chk("flush_yumi.trap_v", 64'(trap_v_o), 64'd0);
        chk("flush_yumi.ready", 64'(exc_ready_o), 64'd1);

        // Flush drops a same-cycle exception
        exc_v_i = 1'b1; exc_i = 16'h0004; flush_i = 1'b1;
        tick();
        flush_i = 1'b0; exc_v_i = 1'b0;
        chk("flush_exc.trap_v", 64'(trap_v_o), 64'd0);
        chk("flush_exc.ready", 64'(exc_ready_o), 64'd1);

        // Reserved bits only
        exc_v_i = 1'b1; exc_i = 16'h4400;
        tick();
        chk("reserved.trap_v", 64'(trap_v_o), 64'd0);
        chk("reserved.ready", 64'(exc_ready_o), 64'd1);

        // ecall_m
        exc_i = 16'h0800;
        tick();
        exc_v_i = 1'b0;
        chk("ecall.trap_v", 64'(trap_v_o), 64'd1);
        chk("ecall.cause", 64'(cause_o), 64'd11);
        chk("ecall.tval", tval_o, 64'd0);

        // Randomized traffic
        for (int cyc = 0; cyc < 1500; cyc++) begin
            exc_v_i = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 3))
                0: exc_i = 16'(1) << $urandom_range(0, 15);
                1: exc_i = 16'($urandom);
                2: exc_i = 16'($urandom) & 16'($urandom) & 16'($urandom);
                default: exc_i = ($urandom_range(0, 1) == 1) ? 16'h4400 : 16'h0000;
            endcase
            pc_i        = {7'($urandom), 32'($urandom)};
            vaddr_i     = {7'($urandom), 32'($urandom)};
            instr_i     = $urandom;
            flush_i     = ($urandom_range(0, 15) == 0);
            trap_yumi_i = m_pending && ($urandom_range(0, 2) == 0);
            tick();
            cmp_model("rand");
        end
        exc_v_i = 1'b0; flush_i = 1'b0; trap_yumi_i = 1'b0;

        // Async reset while a trap is held
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        exc_v_i = 1'b1; exc_i = 16'h0004; instr_i = 32'hDEAD_BEEF;
        tick();
        exc_v_i = 1'b0;
        chk("pre_arst.trap_v", 64'(trap_v_o), 64'd1);
        #2;
        reset_i = 1'b1;
        #1;
        chk("arst.trap_v", 64'(trap_v_o), 64'd0);
        chk("arst.cause", 64'(cause_o), 64'd0);
        chk("arst.tval", tval_o, 64'd0);
        chk("arst.epc", epc_o, 64'd0);
        chk("arst.ready", 64'(exc_ready_o), 64'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
        m_pending = 1'b0; m_drain_left = 0;
        tick();
        chk("arst_rel.ready", 64'(exc_ready_o), 64'd1);
        chk("arst_rel.trap_v", 64'(trap_v_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
